eprom_prog_ctrl: RTL and testbench
==================================

Name: eprom_prog_ctrl

Overview:
Programming sequencer for the 16x16 EPROM array. On a start pulse it:
- erases the whole array;
- blank-checks every word;
- programs DEPTH words taken from a valid/ready input stream, verifying each word by readback immediately after it is written.
It sits between the host/loader and the EPROM write port (addr, we, write_data, erase), and reads the EPROM's combinational data output. It reports busy/done/fail with an error code and the failing address.

Parameters:
ADDR_W, 4, EPROM address width
DATA_W, 16, EPROM word width
DEPTH, 16, number of words erased, checked and programmed (must be <= 2**ADDR_W)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a sequence; honoured only in IDLE, DONE or FAIL
abort  input  1  synchronous abort; honoured only while busy
in_valid  input  1  program-word stream valid
in_data  input  DATA_W  program word
in_ready  output  1  controller accepts in_data this cycle
mem_addr  output  ADDR_W  EPROM address
mem_we  output  1  EPROM write enable
mem_wdata  output  DATA_W  EPROM write data
mem_erase  output  1  EPROM bulk erase
mem_rdata  input  DATA_W  EPROM combinational read data for mem_addr
busy  output  1  sequence in progress
done  output  1  sequence completed without error (sticky)
fail  output  1  sequence terminated with error (sticky)
err_code  output  2  0 none, 1 blank-check fail, 2 verify fail, 3 abort
err_addr  output  ADDR_W  address at which the error occurred (0 for abort)
prog_count  output  ADDR_W+1  words programmed and verified in the current sequence

Behaviour:
- Reset (async, any state): state=IDLE; busy=done=fail=0; err_code=0; err_addr=0; prog_count=0; cnt=0.
- mem_we, mem_erase and in_ready are combinational from the state and are 0 outside the states listed below. mem_wdata=in_data.
- States:
  - IDLE / DONE / FAIL:
    - mem_addr=0, busy=0.
    - start -> ERASE; clears done, fail, err_code, err_addr, prog_count and cnt.
  - ERASE:
    - mem_erase=1 for exactly 1 cycle, then -> BLANK.
  - BLANK:
    - mem_addr=cnt; requires mem_rdata==0.
    - Mismatch -> FAIL, err_code=1, err_addr=cnt.
    - Match at cnt==DEPTH-1 -> PROG with cnt=0; otherwise cnt++.
  - PROG:
    - in_ready=1, mem_addr=cnt, mem_we=in_valid.
    - On in_valid: latch in_data into the expect register and go to VERIFY.
    - Without in_valid: stay in PROG, no write.
  - VERIFY:
    - mem_addr=cnt; compares mem_rdata with the expect register.
    - Mismatch -> FAIL, err_code=2, err_addr=cnt.
    - Match: prog_count++; if cnt==DEPTH-1 -> DONE (done=1), else cnt++ and -> PROG.
- busy=1 in ERASE, BLANK, PROG and VERIFY. busy rises the cycle after start is sampled.
- Minimum sequence length (in_valid held high): 1 + DEPTH + 2*DEPTH cycles = 49 for DEPTH=16.
- abort while busy:
  - Takes priority over every transition in that cycle, including a PROG write. mem_we is forced 0 when abort=1.
  - -> FAIL, err_code=3, err_addr=0.
- start while busy: ignored. abort while not busy: ignored. start and abort together in IDLE: start wins.
- cnt never wraps. The terminal checks use DEPTH-1, so a DEPTH smaller than 2**ADDR_W leaves the upper addresses erased and unchecked.
- Reset mid-sequence: the controller returns to IDLE. EPROM contents are left partial; the host must restart with start.

Test Plan:
- Full run: start, in_valid=1, in_data=16'hA500+index -> busy for 49 cycles; done=1; prog_count=16; EPROM[i]=16'hA500+i; err_code=0.
- Stream stall: in_valid is dropped for 3 cycles before word 5 -> mem_we=0 during the stall; no address advance; sequence completes in 52 cycles with done=1.
- Verify fail: bench model corrupts the readback of addr 7 (bit 0 flipped) -> fail=1, err_code=2, err_addr=7, prog_count=7, done=0.
- Blank fail: bench model ignores erase at addr 3 (keeps 16'h0004) -> fail=1, err_code=1, err_addr=3; no mem_we ever asserted.
- Abort in PROG with in_valid=1 at word 2 -> no write that cycle; fail=1, err_code=3, err_addr=0; a following start runs to done.
- Async reset asserted mid-VERIFY, between clock edges -> outputs zero immediately; state IDLE; a start after deassertion runs the full 49-cycle sequence.

Source files
------------

// File: rtl/eprom_prog_ctrl.sv
// eprom_prog_ctrl: erase, blank-check, then program-and-verify sequencer for a small EPROM array
module eprom_prog_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_erase_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fail_o,
    output logic [1:0]        err_code_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic [ADDR_W:0]   prog_count_o
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ERASE  = 3'd1;
    localparam logic [2:0] S_BLANK  = 3'd2;
    localparam logic [2:0] S_PROG   = 3'd3;
    localparam logic [2:0] S_VERIFY = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_FAIL   = 3'd6;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              done_q, done_d, fail_q, fail_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [ADDR_W:0]   prog_count_q, prog_count_d;
    logic              idle;

    assign idle         = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_FAIL);
    assign busy_o       = !idle;
    assign in_ready_o   = state_q == S_PROG;
    assign mem_we_o     = (state_q == S_PROG) && in_valid_i && !abort_i;
    assign mem_erase_o  = state_q == S_ERASE;
    assign mem_wdata_o  = in_data_i;
    assign mem_addr_o   = idle ? '0 : cnt_q;
    assign done_o       = done_q;
    assign fail_o       = fail_q;
    assign err_code_o   = err_code_q;
    assign err_addr_o   = err_addr_q;
    assign prog_count_o = prog_count_q;

    // Next-state logic: start from a resting state, abort overrides everything while busy
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        exp_d        = exp_q;
        done_d       = done_q;
        fail_d       = fail_q;
        err_code_d   = err_code_q;
        err_addr_d   = err_addr_q;
        prog_count_d = prog_count_q;
        if (idle && start_i) begin
            state_d      = S_ERASE;
            cnt_d        = '0;
            done_d       = 1'b0;
            fail_d       = 1'b0;
            err_code_d   = 2'd0;
            err_addr_d   = '0;
            prog_count_d = '0;
        end else if (!idle && abort_i) begin
            state_d    = S_FAIL;
            fail_d     = 1'b1;
            err_code_d = 2'd3;
            err_addr_d = '0;
        end else begin
            case (state_q)
                S_ERASE: state_d = S_BLANK;
                S_BLANK: begin
                    if (mem_rdata_i != '0) begin
                        state_d    = S_FAIL;
                        fail_d     = 1'b1;
                        err_code_d = 2'd1;
                        err_addr_d = cnt_q;
                    end else if (cnt_q == LAST) begin
                        state_d = S_PROG;
                        cnt_d   = '0;
                    end else cnt_d = cnt_q + 1'b1;
                end
                S_PROG: begin
                    if (in_valid_i) begin
                        exp_d   = in_data_i;
                        state_d = S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (mem_rdata_i != exp_q) begin
                        state_d    = S_FAIL;
                        fail_d     = 1'b1;
                        err_code_d = 2'd2;
                        err_addr_d = cnt_q;
                    end else begin
                        prog_count_d = prog_count_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = S_PROG;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            exp_q        <= '0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            err_code_q   <= 2'd0;
            err_addr_q   <= '0;
            prog_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            exp_q        <= exp_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            err_code_q   <= err_code_d;
            err_addr_q   <= err_addr_d;
            prog_count_q <= prog_count_d;
        end
    end
endmodule

// File: tb/tb_eprom_prog_ctrl.sv
// tb_eprom_prog_ctrl: randomized scenario bench with an EPROM model and outcome-level reference
module tb_eprom_prog_ctrl;
    logic        clk = 0, rst = 1;
    logic        start = 0, abort = 0, in_valid = 0;
    logic [15:0] in_data = 0;
    logic        in_ready, mem_we, mem_erase, busy, done, fail;
    logic [3:0]  mem_addr, err_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic [1:0]  err_code;
    logic [4:0]  prog_count;
    logic [15:0] mem [16];
    bit          written [16];
    logic [15:0] data [16];
    int          bf_addr = -1, vf_addr = -1;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    eprom_prog_ctrl #(.ADDR_W(4), .DATA_W(16), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_erase_o(mem_erase), .mem_rdata_i(mem_rdata), .busy_o(busy),
        .done_o(done), .fail_o(fail), .err_code_o(err_code),
        .err_addr_o(err_addr), .prog_count_o(prog_count)
    );

    // EPROM model: a stuck cell ignores erase, a weak cell reads back with bit 0 flipped once written
    assign mem_rdata = mem[mem_addr] ^ {15'd0, (vf_addr == int'(mem_addr)) && written[mem_addr]};

    always @(posedge clk) begin
        if (mem_erase)
            for (int i = 0; i < 16; i++) if (i != bf_addr) mem[i] = 16'd0;
        if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            written[mem_addr] = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One sequence; stall/fault/abort positions of -1 mean "not used"
    task automatic run(input int stall_w, input int stall_l, input int vf, input int bf,
                       input int ab_w, input bit sa, input bit rnd);
        int cyc, stalled, widx, wes, n, lim, extra, ecyc, bad, ecode, eaddr, epc;
        logic [15:0] ev;
        for (int i = 0; i < 16; i++) begin
            data[i] = rnd ? 16'($urandom) : 16'hA500 + 16'(i);
            mem[i] = 16'($urandom);
            written[i] = 0;
        end
        bf_addr = bf;
        vf_addr = vf;
        if (bf >= 0) mem[bf] = 16'h0004;
        @(negedge clk);
        start = 1;
        abort = sa;
        @(negedge clk);
        start = 0;
        abort = 0;
        cyc = 0; stalled = 0; widx = 0; wes = 0;
        while (busy && cyc < 200) begin
            in_valid = 0;
            in_data = data[widx[3:0]];
            if (in_ready) begin
                if (widx == stall_w && stalled < stall_l) stalled++;
                else begin
                    in_valid = 1;
                    abort = (widx == ab_w);
                end
            end
            if (cyc == 5) start = 1;
            #1;
            if (abort) chk("we_abort", mem_we, 0);
            if (in_ready && !in_valid) begin
                chk("we_stall", mem_we, 0);
                chk("addr_stall", mem_addr, widx);
            end
            if (mem_we) wes++;
            if (in_ready && in_valid && !abort) widx++;
            cyc++;
            @(negedge clk);
            start = 0;
            abort = 0;
            in_valid = 0;
        end
        chk("timeout", cyc < 200, 1);
        lim = (ab_w >= 0) ? ab_w : (vf >= 0) ? vf : 15;
        extra = (stall_w >= 0 && stall_w <= lim) ? stall_l : 0;
        if (bf >= 0) begin
            ecode = 1; eaddr = bf; epc = 0; n = 0; ecyc = 2 + bf;
        end else if (ab_w >= 0) begin
            ecode = 3; eaddr = 0; epc = ab_w; n = ab_w; ecyc = 18 + 2 * ab_w + extra;
        end else if (vf >= 0) begin
            ecode = 2; eaddr = vf; epc = vf; n = vf + 1; ecyc = 19 + 2 * vf + extra;
        end else begin
            ecode = 0; eaddr = 0; epc = 16; n = 16; ecyc = 49 + extra;
        end
        chk("cycles", cyc, ecyc);
        chk("done", done, ecode == 0);
        chk("fail", fail, ecode != 0);
        chk("err_code", err_code, ecode);
        chk("err_addr", err_addr, eaddr);
        chk("prog_count", prog_count, epc);
        chk("writes", wes, n);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            ev = (i < n) ? data[i] : (i == bf) ? 16'h0004 : 16'h0000;
            if (mem[i] !== ev) bad++;
        end
        chk("mem_image", bad, 0);
        bf_addr = -1;
        vf_addr = -1;
    endtask

    initial begin
        int k, a;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_flags", {done, fail, err_code, err_addr, prog_count}, 0);
        chk("rst_strobes", {in_ready, mem_we, mem_erase, mem_addr}, 0);
        @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("idle_abort", {busy, fail, err_code}, 0);
        rst = 0;
        run(-1, 0, -1, -1, -1, 0, 0);
        run(5, 3, -1, -1, -1, 0, 1);
        run(-1, 0, 7, -1, -1, 0, 1);
        run(-1, 0, -1, 3, -1, 0, 1);
        run(-1, 0, -1, -1, 2, 0, 1);
        run(-1, 0, -1, -1, -1, 1, 1);
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        in_valid = 1;
        in_data = 16'h1234;
        repeat (18) @(negedge clk);
        chk("pre_rst_verify", {busy, in_ready}, 2'b10);
        #2 rst = 1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_out", {done, fail, err_code, err_addr, prog_count, mem_addr, mem_we, in_ready}, 0);
        @(negedge clk);
        rst = 0;
        in_valid = 0;
        run(-1, 0, -1, -1, -1, 0, 1);
        for (int r = 0; r < 8; r++) begin
            k = $urandom_range(0, 3);
            a = $urandom_range(0, 15);
            case (k)
                0: run($urandom_range(0, 15), $urandom_range(1, 4), -1, -1, -1, 0, 1);
                1: run($urandom_range(0, 15), $urandom_range(1, 4), a, -1, -1, 0, 1);
                2: run(-1, 0, -1, a, -1, 0, 1);
                default: run($urandom_range(0, 15), $urandom_range(1, 4), -1, -1, a, 0, 1);
            endcase
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
